// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: trap context from the detection stage in,
// flush/redirect/status controls back out to the pipeline.
interface trap_sequencer_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic [2:0]       trap_type;
  logic [XLEN-1:0]  mtvec_addr;
  logic [XLEN-1:0]  mepc;
  logic             mret;
  logic             flush_if;
  logic             flush_id;
  logic             flush_ex;
  logic             flush_mem;
  logic             stall_fetch;
  logic             pc_redirect_valid;
  logic [XLEN-1:0]  pc_redirect;
  logic             in_handler;
  logic [2:0]       mcause_q;
  logic             halted;
  logic [CNT_W-1:0] trap_count;

  // Trap-detection / decode side: supplies the trap context.
  modport master (
    output trap_type, mtvec_addr, mepc, mret,
    input  flush_if, flush_id, flush_ex, flush_mem, stall_fetch,
    input  pc_redirect_valid, pc_redirect, in_handler, mcause_q,
    input  halted, trap_count
  );

  // Sequencer side: consumes the context, drives pipeline controls.
  modport slave (
    input  trap_type, mtvec_addr, mepc, mret,
    output flush_if, flush_id, flush_ex, flush_mem, stall_fetch,
    output pc_redirect_valid, pc_redirect, in_handler, mcause_q,
    output halted, trap_count
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/return sequencer for the RV64I pipeline.
// Latches trap context, flushes the pipe for FLUSH_CYCLES, redirects
// fetch to the handler, returns on mret and halts on a double fault.
// Outputs are registered from the current state, so each state's
// effect is visible one cycle after the state is entered.
module trap_sequencer #(
  parameter int FLUSH_CYCLES = 3,
  parameter int XLEN         = 64,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rstn,
  trap_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FLUSH    = 3'd1;
  localparam logic [2:0] S_REDIRECT = 3'd2;
  localparam logic [2:0] S_HANDLER  = 3'd3;
  localparam logic [2:0] S_RETURN   = 3'd4;
  localparam logic [2:0] S_HALT     = 3'd5;

  // Counter preload so that FLUSH lasts exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  // Saturating increment: trap_count sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end else begin
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]  vec_q, vec_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [2:0]       mcause_q, mcause_d;
  logic [CNT_W-1:0] trap_count_q, trap_count_d;

  // Registered output copies; flush_q bit order is {mem, ex, id, if}.
  logic [3:0]       flush_q, flush_d;
  logic             stall_q, stall_d;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             in_handler_q, in_handler_d;
  logic             halted_q, halted_d;

  logic             trap_s;

  assign trap_s = (bus.trap_type != 3'b000);

  // Next-state and trap-context capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vec_d        = vec_q;
    epc_d        = epc_q;
    mcause_d     = mcause_q;
    trap_count_d = trap_count_q;
    case (state_q)
      S_IDLE: begin
        // A trap beats a simultaneous mret; a lone mret is ignored here.
        if (trap_s) begin
          mcause_d     = bus.trap_type;
          vec_d        = bus.mtvec_addr;
          epc_d        = bus.mepc;
          cnt_d        = FLUSH_LOAD;
          trap_count_d = sat_inc(trap_count_q);
          state_d      = S_FLUSH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        // The originating fault is still visible upstream, so trap_type is ignored.
        if (cnt_q == 4'd0) begin
          state_d = S_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REDIRECT: begin
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        // A trap inside the handler is a double fault and wins over mret.
        if (trap_s) begin
          mcause_d     = bus.trap_type;
          trap_count_d = sat_inc(trap_count_q);
          state_d      = S_HALT;
        end else if (bus.mret) begin
          state_d = S_RETURN;
        end else begin
          state_d = S_HANDLER;
        end
      end
      S_RETURN: begin
        state_d = S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values implied by the current state.
  always_comb begin
    flush_d      = 4'b0000;
    stall_d      = 1'b0;
    valid_d      = 1'b0;
    pc_d         = pc_q;
    in_handler_d = 1'b0;
    halted_d     = 1'b0;
    case (state_q)
      S_FLUSH: begin
        flush_d = 4'b1111;
        stall_d = 1'b1;
      end
      S_REDIRECT: begin
        valid_d = 1'b1;
        pc_d    = vec_q;
      end
      S_HANDLER: begin
        in_handler_d = 1'b1;
      end
      S_RETURN: begin
        valid_d      = 1'b1;
        pc_d         = epc_q;
        flush_d      = 4'b0011;
        in_handler_d = 1'b1;
      end
      S_HALT: begin
        halted_d = 1'b1;
        stall_d  = 1'b1;
        flush_d  = 4'b1111;
      end
      default: begin
        flush_d = 4'b0000;
      end
    endcase
  end

  // State and latched trap context.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      vec_q        <= {XLEN{1'b0}};
      epc_q        <= {XLEN{1'b0}};
      mcause_q     <= 3'b000;
      trap_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_q        <= vec_d;
      epc_q        <= epc_d;
      mcause_q     <= mcause_d;
      trap_count_q <= trap_count_d;
    end
  end

  // Registered pipeline-control outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush_q      <= 4'b0000;
      stall_q      <= 1'b0;
      valid_q      <= 1'b0;
      pc_q         <= {XLEN{1'b0}};
      in_handler_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      flush_q      <= flush_d;
      stall_q      <= stall_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      in_handler_q <= in_handler_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.flush_if          = flush_q[0];
  assign bus.flush_id          = flush_q[1];
  assign bus.flush_ex          = flush_q[2];
  assign bus.flush_mem         = flush_q[3];
  assign bus.stall_fetch       = stall_q;
  assign bus.pc_redirect_valid = valid_q;
  assign bus.pc_redirect       = pc_q;
  assign bus.in_handler        = in_handler_q;
  assign bus.mcause_q          = mcause_q;
  assign bus.halted            = halted_q;
  assign bus.trap_count        = trap_count_q;

endmodule
